// File: rtl/bomberman_pkg.sv
// Shared types and constants for the per-player motion and bomb logic.
package bomberman_pkg;

    localparam int COORD_W = 4;

    typedef enum logic [1:0] {
        READY    = 2'd0,
        PROBE    = 2'd1,
        COOLDOWN = 2'd2
    } move_state_e;

    typedef enum logic {
        NONE = 1'b0,
        FUSE = 1'b1
    } bomb_state_e;

    localparam logic DIR_LEFT  = 1'b0;
    localparam logic DIR_RIGHT = 1'b1;
    localparam logic DIR_UP    = 1'b0;
    localparam logic DIR_DOWN  = 1'b1;

    // Only called once the bounds check has passed, so no wrap is possible.
    function automatic logic [COORD_W-1:0] step_coord(input logic [COORD_W-1:0] c,
                                                      input logic               inc);
        return inc ? c + COORD_W'(1) : c - COORD_W'(1);
    endfunction

endpackage

// File: rtl/bomb_fuse_timer.sv
// Single-bomb placement and fuse countdown for one player.
// Optional macro BOMB_EDGE_EN: place bombs only on a rising edge of bomb_req.
module bomb_fuse_timer
    import bomberman_pkg::*;
#(
    parameter int unsigned FUSE_CYCLES = 100000000
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               enable,
    input  logic               bomb_req,
    input  logic [COORD_W-1:0] pos_x,
    input  logic [COORD_W-1:0] pos_y,
    output logic               bomb_place,
    output logic [COORD_W-1:0] bomb_x,
    output logic [COORD_W-1:0] bomb_y,
    output logic               bomb_active,
    output logic               bomb_explode
);

    localparam int FUSE_CW = (FUSE_CYCLES > 1) ? $clog2(FUSE_CYCLES) : 1;
    localparam logic [FUSE_CW-1:0] FUSE_RELOAD = FUSE_CW'(FUSE_CYCLES - 1);

    bomb_state_e        state_q, state_d;
    logic [FUSE_CW-1:0] cnt_q, cnt_d;
    logic [COORD_W-1:0] bomb_x_q, bomb_x_d;
    logic [COORD_W-1:0] bomb_y_q, bomb_y_d;
    logic               place_q, place_d;
    logic               explode_q, explode_d;
    logic               arm;

`ifdef BOMB_EDGE_EN
    logic req_prev_q, req_prev_d;

    assign req_prev_d = bomb_req;
    assign arm        = enable & bomb_req & ~req_prev_q;

    always_ff @(posedge clock) begin
        if (reset) req_prev_q <= 1'b0;
        else       req_prev_q <= req_prev_d;
    end
`else
    assign arm = enable & bomb_req;
`endif

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        bomb_x_d  = bomb_x_q;
        bomb_y_d  = bomb_y_q;
        place_d   = 1'b0;
        explode_d = 1'b0;
        case (state_q)
            NONE: begin
                if (arm) begin
                    bomb_x_d = pos_x;
                    bomb_y_d = pos_y;
                    place_d  = 1'b1;
                    cnt_d    = FUSE_RELOAD;
                    state_d  = FUSE;
                end
            end
            FUSE: begin
                if (cnt_q == '0) begin
                    explode_d = 1'b1;
                    state_d   = NONE;
                end else begin
                    cnt_d = cnt_q - FUSE_CW'(1);
                end
            end
            default: state_d = NONE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= NONE;
            cnt_q     <= '0;
            bomb_x_q  <= '0;
            bomb_y_q  <= '0;
            place_q   <= 1'b0;
            explode_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bomb_x_q  <= bomb_x_d;
            bomb_y_q  <= bomb_y_d;
            place_q   <= place_d;
            explode_q <= explode_d;
        end
    end

    assign bomb_place   = place_q;
    assign bomb_x       = bomb_x_q;
    assign bomb_y       = bomb_y_q;
    assign bomb_active  = (state_q == FUSE);
    assign bomb_explode = explode_q;

endmodule

// File: rtl/player_motion_ctrl.sv
// Per-player move FSM (rate-limited, map-probed grid steps) plus bomb timer.
// Optional macro BOMB_EDGE_EN is forwarded to bomb_fuse_timer.
module player_motion_ctrl
    import bomberman_pkg::*;
#(
    parameter int unsigned GRID_W      = 15,
    parameter int unsigned GRID_H      = 11,
    parameter int unsigned START_X     = 1,
    parameter int unsigned START_Y     = 1,
    parameter int unsigned MOVE_PERIOD = 12500000,
    parameter int unsigned FUSE_CYCLES = 100000000
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               enable,
    input  logic               bomb_req,
    input  logic               xdir,
    input  logic               ydir,
    input  logic               xmov,
    input  logic               ymov,
    input  logic               target_blocked,
    output logic [COORD_W-1:0] pos_x,
    output logic [COORD_W-1:0] pos_y,
    output logic [COORD_W-1:0] target_x,
    output logic [COORD_W-1:0] target_y,
    output logic               target_valid,
    output logic               moved,
    output logic               bomb_place,
    output logic [COORD_W-1:0] bomb_x,
    output logic [COORD_W-1:0] bomb_y,
    output logic               bomb_active,
    output logic               bomb_explode
);

    localparam int MOVE_CW = (MOVE_PERIOD > 1) ? $clog2(MOVE_PERIOD) : 1;
    localparam logic [MOVE_CW-1:0] MOVE_RELOAD = MOVE_CW'(MOVE_PERIOD - 1);
    localparam logic [COORD_W-1:0] X_MAX       = COORD_W'(GRID_W - 1);
    localparam logic [COORD_W-1:0] Y_MAX       = COORD_W'(GRID_H - 1);

    move_state_e        state_q, state_d;
    logic [MOVE_CW-1:0] cnt_q, cnt_d;
    logic [COORD_W-1:0] pos_x_q, pos_x_d;
    logic [COORD_W-1:0] pos_y_q, pos_y_d;
    logic [COORD_W-1:0] tgt_x_q, tgt_x_d;
    logic [COORD_W-1:0] tgt_y_q, tgt_y_d;
    logic               moved_q, moved_d;
    logic               at_edge;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pos_x_d = pos_x_q;
        pos_y_d = pos_y_q;
        tgt_x_d = tgt_x_q;
        tgt_y_d = tgt_y_q;
        moved_d = 1'b0;
        at_edge = 1'b0;
        case (state_q)
            READY: begin
                if (enable && (xmov || ymov)) begin
                    if (xmov) begin
                        at_edge = (xdir == DIR_RIGHT) ? (pos_x_q == X_MAX) : (pos_x_q == '0);
                    end else begin
                        at_edge = (ydir == DIR_DOWN) ? (pos_y_q == Y_MAX) : (pos_y_q == '0);
                    end
                    if (!at_edge) begin
                        tgt_x_d = xmov ? step_coord(pos_x_q, xdir == DIR_RIGHT) : pos_x_q;
                        tgt_y_d = xmov ? pos_y_q : step_coord(pos_y_q, ydir == DIR_DOWN);
                        state_d = PROBE;
                    end
                end
            end
            PROBE: begin
                if (!target_blocked) begin
                    pos_x_d = tgt_x_q;
                    pos_y_d = tgt_y_q;
                    moved_d = 1'b1;
                    cnt_d   = MOVE_RELOAD;
                    state_d = COOLDOWN;
                end else begin
                    state_d = READY;
                end
            end
            COOLDOWN: begin
                if (cnt_q == '0) state_d = READY;
                else             cnt_d   = cnt_q - MOVE_CW'(1);
            end
            default: state_d = READY;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= READY;
            cnt_q   <= '0;
            pos_x_q <= COORD_W'(START_X);
            pos_y_q <= COORD_W'(START_Y);
            tgt_x_q <= '0;
            tgt_y_q <= '0;
            moved_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pos_x_q <= pos_x_d;
            pos_y_q <= pos_y_d;
            tgt_x_q <= tgt_x_d;
            tgt_y_q <= tgt_y_d;
            moved_q <= moved_d;
        end
    end

    assign pos_x        = pos_x_q;
    assign pos_y        = pos_y_q;
    assign target_x     = tgt_x_q;
    assign target_y     = tgt_y_q;
    assign target_valid = (state_q == PROBE);
    assign moved        = moved_q;

    // Bomb latches the pre-commit position register, so a same-edge move is not seen.
    bomb_fuse_timer #(
        .FUSE_CYCLES(FUSE_CYCLES)
    ) u_bomb (
        .clock       (clock),
        .reset       (reset),
        .enable      (enable),
        .bomb_req    (bomb_req),
        .pos_x       (pos_x_q),
        .pos_y       (pos_y_q),
        .bomb_place  (bomb_place),
        .bomb_x      (bomb_x),
        .bomb_y      (bomb_y),
        .bomb_active (bomb_active),
        .bomb_explode(bomb_explode)
    );

endmodule

// File: tb/tb_player_motion_ctrl.sv
// Self-checking bench for player_motion_ctrl: timestamp-based reference model,
// directed scenarios with literal pins, then randomized stimulus.
module tb_player_motion_ctrl;

    localparam int GW = 15;
    localparam int GH = 11;
    localparam int SX = 1;
    localparam int SY = 1;
    localparam int MP = 4;
    localparam int FC = 5;

    logic       clock = 1'b0;
    logic       reset, enable, bomb_req, xdir, ydir, xmov, ymov, target_blocked;
    logic [3:0] pos_x, pos_y, target_x, target_y, bomb_x, bomb_y;
    logic       target_valid, moved, bomb_place, bomb_active, bomb_explode;

    int n_total = 0;
    int n_bad   = 0;

    player_motion_ctrl #(
        .GRID_W(GW), .GRID_H(GH), .START_X(SX), .START_Y(SY),
        .MOVE_PERIOD(MP), .FUSE_CYCLES(FC)
    ) dut (
        .clock(clock), .reset(reset), .enable(enable), .bomb_req(bomb_req),
        .xdir(xdir), .ydir(ydir), .xmov(xmov), .ymov(ymov),
        .target_blocked(target_blocked),
        .pos_x(pos_x), .pos_y(pos_y), .target_x(target_x), .target_y(target_y),
        .target_valid(target_valid), .moved(moved), .bomb_place(bomb_place),
        .bomb_x(bomb_x), .bomb_y(bomb_y), .bomb_active(bomb_active),
        .bomb_explode(bomb_explode)
    );

    always #5 clock = ~clock;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at t=%0t", nm, act, exp, $time);
        end
    endtask

    task automatic timeout(input string nm);
        n_total++;
        n_bad++;
        $display("FAIL %s: wait bound expired at t=%0t", nm, $time);
    endtask

    // Reference model: expected outputs for the next cycle, driven by event timestamps.
    bit model_on = 0;
    int m_c = 0;
    int m_ready_at, m_probe_at, m_explode_at, m_bomb_free_at;
    bit m_prev;
    int e_px, e_py, e_tx, e_ty, e_bx, e_by;
    bit e_tv, e_moved, e_place, e_active, e_expl;
    int nc, tx, ty;
    bit req_ok;

    always @(negedge clock) begin
        if (model_on) begin
            check("pos_x", pos_x, e_px);
            check("pos_y", pos_y, e_py);
            check("target_valid", target_valid, e_tv);
            if (e_tv) begin
                check("target_x", target_x, e_tx);
                check("target_y", target_y, e_ty);
            end
            check("moved", moved, e_moved);
            check("bomb_place", bomb_place, e_place);
            check("bomb_x", bomb_x, e_bx);
            check("bomb_y", bomb_y, e_by);
            check("bomb_active", bomb_active, e_active);
            check("bomb_explode", bomb_explode, e_expl);
        end
        nc = m_c + 1;
        if (reset === 1'b1) begin
            e_px = SX; e_py = SY; e_bx = 0; e_by = 0;
            e_tv = 0; e_moved = 0; e_place = 0; e_active = 0; e_expl = 0;
            m_ready_at = nc; m_probe_at = -1; m_explode_at = -1; m_bomb_free_at = nc;
            m_prev = 0;
            model_on = 1;
        end else if (model_on) begin
            e_moved = 0; e_place = 0; e_expl = 0;
            if (m_explode_at == nc) begin
                e_expl = 1;
                e_active = 0;
            end
`ifdef BOMB_EDGE_EN
            req_ok = enable && bomb_req && !m_prev;
`else
            req_ok = enable && bomb_req;
`endif
            if (m_c >= m_bomb_free_at && req_ok) begin
                e_place = 1; e_active = 1; e_bx = e_px; e_by = e_py;
                m_explode_at = nc + FC;
                m_bomb_free_at = nc + FC;
            end
            m_prev = bomb_req;
            if (m_probe_at == m_c) begin
                if (!target_blocked) begin
                    e_px = e_tx; e_py = e_ty; e_moved = 1;
                    m_ready_at = nc + MP;
                end else begin
                    m_ready_at = nc;
                end
                m_probe_at = -1;
            end else if (m_c >= m_ready_at && enable && (xmov || ymov)) begin
                tx = e_px; ty = e_py;
                if (xmov) tx = tx + (xdir ? 1 : -1);
                else      ty = ty + (ydir ? 1 : -1);
                if (tx >= 0 && tx < GW && ty >= 0 && ty < GH) begin
                    m_probe_at = nc; e_tx = tx; e_ty = ty;
                    m_ready_at = 1 << 30;
                end
            end
            e_tv = (m_probe_at == nc);
        end
        m_c++;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic idle();
        xmov = 0; ymov = 0; bomb_req = 0; target_blocked = 0;
    endtask

    task automatic go_to(input int gx, input int gy);
        enable = 1;
        target_blocked = 0;
        for (int i = 0; i < 300; i++) begin
            if (pos_x == gx && pos_y == gy) begin
                idle();
                return;
            end
            if (pos_x != gx) begin
                xmov = 1; ymov = 0; xdir = (gx > int'(pos_x));
            end else begin
                xmov = 0; ymov = 1; ydir = (gy > int'(pos_y));
            end
            tick(1);
        end
        idle();
        timeout("go_to");
    endtask

    task automatic wait_tv(input string nm);
        for (int i = 0; i < 50; i++) begin
            if (target_valid === 1'b1) return;
            tick(1);
        end
        timeout(nm);
    endtask

    int places;

    initial begin
        reset = 1; enable = 0; xdir = 0; ydir = 0;
        idle();
        tick(3);
        check("pin_reset_x", pos_x, 1);
        check("pin_reset_y", pos_y, 1);
        check("pin_reset_active", bomb_active, 0);
        check("pin_reset_tv", target_valid, 0);
        reset = 0; enable = 1;

        // Held right move from (1,1): x=2 at N+2, x=3 at N+8
        xmov = 1; xdir = 1;
        tick(1);
        check("pin_t1_probe", target_valid, 1);
        tick(1);
        check("pin_t1_x2", pos_x, 2);
        check("pin_t1_moved", moved, 1);
        tick(5);
        check("pin_t1_x2_hold", pos_x, 2);
        tick(1);
        check("pin_t1_x3", pos_x, 3);
        idle();

        // Left edge: no probe; then blocked down probe and re-probe after one READY cycle
        go_to(0, 5);
        tick(MP + 2);
        xmov = 1; xdir = 0;
        tick(10);
        check("pin_t2_edge_x", pos_x, 0);
        check("pin_t2_edge_tv", target_valid, 0);
        xmov = 0; ymov = 1; ydir = 1; target_blocked = 1;
        wait_tv("t2_wait");
        check("pin_t2_tx", target_x, 0);
        check("pin_t2_ty", target_y, 6);
        tick(1);
        check("pin_t2_ready_tv", target_valid, 0);
        check("pin_t2_pos_y", pos_y, 5);
        tick(1);
        check("pin_t2_reprobe", target_valid, 1);
        idle();

        // x priority over y
        go_to(3, 3);
        tick(MP + 2);
        xmov = 1; ymov = 1; xdir = 1; ydir = 1; target_blocked = 1;
        wait_tv("t3_wait");
        check("pin_t3_tx", target_x, 4);
        check("pin_t3_ty", target_y, 3);
        idle();
        tick(2);

        // Bomb at (2,2), second request ignored, explode 5 cycles after place
        go_to(2, 2);
        bomb_req = 1;
        tick(1);
        bomb_req = 0;
        check("pin_t4_place", bomb_place, 1);
        check("pin_t4_bx", bomb_x, 2);
        check("pin_t4_by", bomb_y, 2);
        check("pin_t4_active", bomb_active, 1);
        tick(2);
        bomb_req = 1;
        tick(1);
        bomb_req = 0;
        check("pin_t4_ignored", bomb_place, 0);
        tick(1);
        check("pin_t4_no_expl", bomb_explode, 0);
        tick(1);
        check("pin_t4_expl", bomb_explode, 1);
        check("pin_t4_inactive", bomb_active, 0);

        // Reset mid-probe with fuse running
        tick(MP + 2);
        xmov = 1; xdir = 1; bomb_req = 1;
        tick(1);
        check("pin_t5_probe", target_valid, 1);
        check("pin_t5_place", bomb_place, 1);
        idle();
        reset = 1;
        tick(1);
        reset = 0;
        check("pin_t5_x", pos_x, SX);
        check("pin_t5_y", pos_y, SY);
        check("pin_t5_active", bomb_active, 0);
        tick(FC + 4);

        // Held bomb key through an explosion
        bomb_req = 1;
        places = 0;
        for (int i = 0; i < 10; i++) begin
            tick(1);
            if (bomb_place === 1'b1) places++;
        end
`ifdef BOMB_EDGE_EN
        check("pin_t6_places", places, 1);
`else
        check("pin_t6_places", places, 2);
`endif
        bomb_req = 0;
        for (int i = 0; i < 20 && bomb_active !== 1'b0; i++) tick(1);
        if (bomb_active !== 1'b0) timeout("t6_idle");
        tick(1);
        bomb_req = 1;
        tick(1);
        check("pin_t6_repress", bomb_place, 1);
        bomb_req = 0;

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            reset          = ($urandom_range(0, 299) == 0);
            enable         = ($urandom_range(0, 9) != 0);
            xmov           = 1'($urandom_range(0, 1));
            ymov           = 1'($urandom_range(0, 1));
            xdir           = 1'($urandom_range(0, 1));
            ydir           = 1'($urandom_range(0, 1));
            bomb_req       = ($urandom_range(0, 3) == 0);
            target_blocked = 1'($urandom_range(0, 1));
            tick(1);
        end
        reset = 0;
        idle();
        tick(3);
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
